// File: rtl/controle_id_rf.sv
// controle_id_rf: multicycle control for the ID/RF stage.
// Takes one 16-bit instruction per valid/ready handshake and steps it through
// OCIOSO -> DECOD -> EXEC -> {MEMORIA | ESCRITA | OCIOSO}. While it steps, the
// block drives the register bank, extender, ULA and data-memory controls.
//
// Handshake: instr_ready is high only in OCIOSO. An instruction is accepted on
// the rising edge where instr_valid & instr_ready. instr_valid is ignored while
// instr_ready is low; nothing is captured or queued. md_req/md_ack work the same
// way: md_req stays high for every MEMORIA cycle until md_ack or a timeout.
module controle_id_rf #(
   parameter int MD_TIMEOUT = 15  // MEMORIA cycles allowed before abort (1..255)
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   input  logic        md_ack,
   output logic        BR_Hab_Escrita,
   output logic [2:0]  BR_Sel_E_SA,
   output logic [2:0]  BR_Sel_SB,
   output logic [1:0]  EXcontrole,
   output logic [10:0] EXconstante,
   output logic        controle,
   output logic [3:0]  ula_op,
   output logic        ula_src_b,
   output logic        md_req,
   output logic        md_we,
   output logic        pc_load,
   output logic        erro,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      DECOD   = 3'd1,
      EXEC    = 3'd2,
      MEMORIA = 3'd3,
      ESCRITA = 3'd4
   } state_t;

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_ALU  = 5'h01;
   localparam logic [4:0] OP_ADDI = 5'h02;
   localparam logic [4:0] OP_LDI  = 5'h03;
   localparam logic [4:0] OP_LW   = 5'h04;
   localparam logic [4:0] OP_SW   = 5'h05;
   localparam logic [4:0] OP_JMP  = 5'h07;

   // Timer value in the last MEMORIA cycle allowed before the abort.
   localparam logic [7:0] TMO_LAST = 8'(MD_TIMEOUT - 1);

   state_t      state;
   state_t      next_state;
   logic [15:0] ir;
   logic [7:0]  timer;
   logic [4:0]  op;
   logic        op_legal;

   assign op        = ir[15:11];
   assign state_dbg = state;

   // Opcodes outside the defined set make DECOD raise erro.
   always_comb begin
      op_legal = 1'b0;
      case (op)
         OP_NOP, OP_ALU, OP_ADDI, OP_LDI, OP_LW, OP_SW, OP_JMP: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   // State register. Reset aborts any instruction in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= OCIOSO;
      else          state <= next_state;
   end

   // Instruction register. It loads only on the accept edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                          ir <= 16'h0000;
      else if (state == OCIOSO && instr_valid) ir <= instr;
   end

   // MEMORIA cycle counter. It clears whenever the FSM is not waiting on memory.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)               timer <= 8'd0;
      else if (state == MEMORIA)  timer <= timer + 8'd1;
      else                        timer <= 8'd0;
   end

   // Next-state logic and the per-state strobes.
   always_comb begin
      next_state     = state;
      instr_ready    = 1'b0;
      BR_Hab_Escrita = 1'b0;
      controle       = 1'b0;
      md_req         = 1'b0;
      md_we          = 1'b0;
      pc_load        = 1'b0;
      erro           = 1'b0;
      case (state)
         OCIOSO: begin
            instr_ready = 1'b1;
            if (instr_valid) next_state = DECOD;
         end
         DECOD: begin
            if (op == OP_NOP) begin
               next_state = OCIOSO;
            end else if (!op_legal) begin
               erro       = 1'b1;
               next_state = OCIOSO;
            end else begin
               next_state = EXEC;
            end
         end
         EXEC: begin
            case (op)
               OP_LW, OP_SW: next_state = MEMORIA;
               OP_JMP: begin
                  pc_load    = 1'b1;
                  next_state = OCIOSO;
               end
               default: next_state = ESCRITA;
            endcase
         end
         MEMORIA: begin
            md_req = 1'b1;
            md_we  = (op == OP_SW);
            // If md_ack arrives in the timeout cycle, the ack is taken.
            if (md_ack) begin
               next_state = (op == OP_LW) ? ESCRITA : OCIOSO;
            end else if (timer == TMO_LAST) begin
               erro       = 1'b1;
               next_state = OCIOSO;
            end
         end
         ESCRITA: begin
            BR_Hab_Escrita = 1'b1;
            controle       = (op == OP_LW);
            next_state     = OCIOSO;
         end
         default: next_state = OCIOSO;
      endcase
   end

   // Decode of the captured instruction. These outputs hold steady from DECOD
   // until the FSM returns to OCIOSO, and they are zero while idle.
   always_comb begin
      BR_Sel_E_SA = 3'd0;
      BR_Sel_SB   = 3'd0;
      EXconstante = 11'd0;
      EXcontrole  = 2'b00;
      ula_op      = 4'h0;
      ula_src_b   = 1'b0;
      if (state != OCIOSO) begin
         BR_Sel_E_SA = ir[10:8];
         BR_Sel_SB   = ir[7:5];
         EXconstante = ir[10:0];
         case (op)
            OP_ALU: ula_op = ir[3:0];
            OP_ADDI: begin
               EXcontrole = 2'b01;
               ula_src_b  = 1'b1;
            end
            OP_LDI: begin
               ula_op    = 4'hF;
               ula_src_b = 1'b1;
            end
            OP_LW, OP_SW: begin
               EXcontrole = 2'b10;
               ula_src_b  = 1'b1;
            end
            OP_JMP: EXcontrole = 2'b11;
            default: ;
         endcase
      end
   end

endmodule
